// File: rtl/prog_mem_arb.sv
// Shared program memory: one loader write port plus NCORE fetch ports on a single BRAM.
// A round-robin arbiter grants one fetch per cycle; read data is registered and tagged per core.
module prog_mem_arb #(
  parameter int DW    = 18,
  parameter int AW    = 12,
  parameter int NCORE = 4,
  parameter int CW    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [AW-1:0]       WA,
  input  logic [DW-1:0]       DI,
  input  logic [NCORE-1:0]    REQ,
  input  logic [NCORE*AW-1:0] ADDR,
  output logic [NCORE-1:0]    GNT,
  output logic [DW-1:0]       DQ,
  output logic [NCORE-1:0]    DV,
  output logic [CW-1:0]       GIDX
);

  localparam int MEM_SIZE = 1 << AW;

  (* ram_style = "block" *) logic [DW-1:0] mem [MEM_SIZE];

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    gnt_idx;
  logic [CW-1:0]    ptr_next;
  logic             gnt_any;
  logic [NCORE-1:0] gnt_vec;
  logic [AW-1:0]    rd_addr;

  // Rotating search starting at ptr; loader writes and reset suppress every grant.
  always_comb begin
    int k;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    k       = 0;
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    rd_addr = '0;
    if (!RST && !WE) begin
      for (int i = 0; i < NCORE; i++) begin
        k = int'(ptr) + i;
        if (k >= NCORE) k = k - NCORE;
        if (!gnt_any && REQ[k]) begin
          gnt_any    = 1'b1;
          gnt_idx    = CW'(k);
          gnt_vec[k] = 1'b1;
          rd_addr    = ADDR[k*AW +: AW];
        end
      end
    end
  end

  // Explicit wrap keeps the pointer in range when NCORE is not a power of two.
  assign ptr_next = (gnt_idx == CW'(NCORE - 1)) ? '0 : gnt_idx + CW'(1);
  assign GNT      = gnt_vec;

  // NOTE: the storage array has no reset; only control and output registers are cleared.
  always_ff @(posedge CLK) begin
    if (WE) mem[WA] <= DI;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DQ   <= '0;
      DV   <= '0;
      GIDX <= '0;
      ptr  <= '0;
    end else begin
      DV <= gnt_vec;
      if (gnt_any) begin
        DQ   <= mem[rd_addr];
        GIDX <= gnt_idx;
        ptr  <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_arb.sv
// Scoreboard bench for prog_mem_arb: stimulus pushes expected words, a monitor pops and compares.
// A second NCORE=3 instance exercises the non-power-of-two pointer wrap.
module tb_prog_mem_arb;

  typedef struct {
    logic [1:0]  core;
    logic [17:0] data;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [11:0] WA;
  logic [17:0] DI;
  logic [3:0]  REQ;
  logic [47:0] ADDR;
  logic [3:0]  GNT;
  logic [17:0] DQ;
  logic [3:0]  DV;
  logic [1:0]  GIDX;

  logic [2:0]  REQ3;
  logic [35:0] ADDR3;
  logic [2:0]  GNT3;
  logic [17:0] DQ3;
  logic [2:0]  DV3;
  logic [1:0]  GIDX3;

  int n_vec  = 0;
  int n_miss = 0;

  exp_t        sb[$];
  logic [17:0] model_mem [int];

  prog_mem_arb #(.DW(18), .AW(12), .NCORE(4), .CW(2)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .DI(DI), .REQ(REQ), .ADDR(ADDR),
    .GNT(GNT), .DQ(DQ), .DV(DV), .GIDX(GIDX)
  );

  prog_mem_arb #(.DW(18), .AW(12), .NCORE(3), .CW(2)) dut3 (
    .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .DI(DI), .REQ(REQ3), .ADDR(ADDR3),
    .GNT(GNT3), .DQ(DQ3), .DV(DV3), .GIDX(GIDX3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] a4(input logic [11:0] a0, input logic [11:0] a1,
                                     input logic [11:0] a2, input logic [11:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // One clock cycle: drive at edge+1, check the combinational grant at edge+4 and
  // push the word the granted core must receive one cycle later.
  task automatic cycle(input logic we, input logic [11:0] wa, input logic [17:0] di,
                       input logic [3:0] req, input logic [47:0] addr, input logic [3:0] exp_gnt,
                       input logic [2:0] req3 = 3'b000, input logic [2:0] exp_gnt3 = 3'b000);
    exp_t e;
    @(posedge CLK);
    #1;
    WE    = we;
    WA    = wa;
    DI    = di;
    REQ   = req;
    ADDR  = addr;
    REQ3  = req3;
    ADDR3 = {12'h012, 12'h011, 12'h010};
    if (we) model_mem[int'(wa)] = di;
    #3;
    check("gnt", 32'(GNT), 32'(exp_gnt));
    if (req3 != 3'b000) check("gnt3", 32'(GNT3), 32'(exp_gnt3));
    for (int c = 0; c < 4; c++) begin
      if (exp_gnt[c]) begin
        e.core = 2'(c);
        e.data = model_mem[int'(addr[c*12 +: 12])];
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: the entry pushed in cycle t must appear on DQ/DV/GIDX in cycle t+1 only.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("dv",   32'(DV),   32'(4'b0001 << e.core));
        check("dq",   32'(DQ),   32'(e.data));
        check("gidx", 32'(GIDX), 32'(e.core));
      end else begin
        check("dv_idle", 32'(DV), 32'h0);
      end
    end
  end

  initial begin
    RST   = 1'b1;
    WE    = 1'b0;
    WA    = '0;
    DI    = '0;
    REQ   = 4'b1111;
    ADDR  = '0;
    REQ3  = 3'b000;
    ADDR3 = '0;

    #4;
    check("rst_gnt",  32'(GNT),  32'h0);
    check("rst_dv",   32'(DV),   32'h0);
    check("rst_dq",   32'(DQ),   32'h0);
    check("rst_gidx", 32'(GIDX), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ = 4'b0000;

    // Load program words
    cycle(1'b1, 12'h005, 18'h2A5A5, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'hFFF, 18'h3FFFF, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'h010, 18'h00A10, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'h011, 18'h00B11, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'h012, 18'h00C12, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'h013, 18'h00D13, 4'b0000, '0, 4'b0000);
    cycle(1'b1, 12'h100, 18'h0BEEF, 4'b0000, '0, 4'b0000);

    // Single-core fetches, lowest and highest address
    cycle(1'b0, '0, '0, 4'b0001, a4(12'h005, 0, 0, 0), 4'b0001);
    cycle(1'b0, '0, '0, 4'b0001, a4(12'hFFF, 0, 0, 0), 4'b0001);
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000);

    // Grant core 3 so the pointer returns to 0
    cycle(1'b0, '0, '0, 4'b1000, a4(0, 0, 0, 12'h013), 4'b1000);

    // Round robin with all cores requesting
    for (int i = 0; i < 8; i++)
      cycle(1'b0, '0, '0, 4'b1111, a4(12'h010, 12'h011, 12'h012, 12'h013), 4'(1 << (i % 4)));

    // Pointer wrap after core 3
    cycle(1'b0, '0, '0, 4'b1001, a4(12'h005, 0, 0, 12'h013), 4'b0001);
    cycle(1'b0, '0, '0, 4'b1001, a4(12'h005, 0, 0, 12'h013), 4'b1000);

    // Writes block a pending request
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 12'(12'h200 + i), 18'(i + 1), 4'b0010, a4(0, 12'h011, 0, 0), 4'b0000);
    cycle(1'b0, '0, '0, 4'b0010, a4(0, 12'h011, 0, 0), 4'b0010);

    // Read-after-write to 0x100
    cycle(1'b1, 12'h100, 18'h11111, 4'b0000, '0, 4'b0000);
    cycle(1'b0, '0, '0, 4'b0100, a4(0, 0, 12'h100, 0), 4'b0100);

    // Asynchronous reset while DV=0100 is on the outputs
    @(posedge CLK);
    #1;
    WE   = 1'b0;
    REQ  = 4'b1111;
    ADDR = a4(12'h005, 12'h011, 12'h100, 12'h013);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_dv",   32'(DV),   32'h0);
    check("mid_rst_dq",   32'(DQ),   32'h0);
    check("mid_rst_gnt",  32'(GNT),  32'h0);
    check("mid_rst_gidx", 32'(GIDX), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ = 4'b0000;

    // Pointer restarts at 0; memory contents survive reset
    cycle(1'b0, '0, '0, 4'b1111, a4(12'h005, 12'h011, 12'h100, 12'h013), 4'b0001);
    cycle(1'b0, '0, '0, 4'b0100, a4(0, 0, 12'h100, 0), 4'b0100);

    // Three-core instance: order 0,1,2,0
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000, 3'b111, 3'b001);
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000, 3'b111, 3'b010);
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000, 3'b111, 3'b100);
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000, 3'b111, 3'b001);

    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000);
    cycle(1'b0, '0, '0, 4'b0000, '0, 4'b0000);
    @(posedge CLK);
    #3;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prog_mem_arb.md
Name: prog_mem_arb

Overview:
- Shared program memory for the multi-core logic unit.
- One loader write port plus NCORE instruction-fetch ports, served from a single block-RAM array.
- A round-robin arbiter grants one fetch per cycle; read data is registered and tagged with a per-core valid strobe.
- Sits between the program loader and the core array and replaces the per-core single-port program store.

Parameters:
- DW, 18: instruction word width.
- AW, 12: address width; depth MEM_SIZE = 1 << AW.
- NCORE, 4: number of fetch ports (>= 2).
- CW, 2: core index width; CW >= clog2(NCORE).

Ports:
- CLK, in, 1: single clock; all state changes on the rising edge.
- RST, in, 1: asynchronous, active-high reset.
- WE, in, 1: loader write enable.
- WA, in, AW: loader write address.
- DI, in, DW: loader write data.
- REQ, in, NCORE: fetch request, one bit per core.
- ADDR, in, NCORE*AW: fetch addresses; core k uses bits [k*AW +: AW].
- GNT, out, NCORE: one-hot combinational grant for the current cycle.
- DQ, out, DW: registered read data, shared by all cores.
- DV, out, NCORE: one-hot registered data-valid; DV[k] marks DQ as core k's word.
- GIDX, out, CW: registered index of the core owning DQ; meaningful only while |DV.

Behaviour:
- Reset (RST=1, async):
  - DQ=0, DV=0, GIDX=0, round-robin pointer PTR=0.
  - GNT=0 while RST is high.
  - Memory contents are not reset.
- Memory:
  - (* ram_style = "block" *) array of MEM_SIZE x DW.
  - Synchronous write: if WE, MEM[WA] <= DI at the edge.
  - Synchronous read only; no asynchronous read path.
- Write priority:
  - In any cycle with WE=1, GNT=0 and no read is issued.
  - Requests stay pending.
  - PTR does not change.
- Arbitration, when WE=0 and REQ != 0:
  - Search cores PTR, PTR+1, ... modulo NCORE.
  - The first core with REQ set is granted: GNT[g]=1 that cycle.
  - At the edge:
    - DQ <= MEM[ADDR slice g]
    - DV <= one-hot g
    - GIDX <= g
    - PTR <= (g+1) mod NCORE, with explicit wrap for non-power-of-two NCORE.
- Idle cycles: when WE=0 and REQ=0, at the edge DV <= 0, while DQ and GIDX hold their values.
- Latency:
  - Grant in cycle t means data on DQ with DV[g]=1 during cycle t+1 only (one cycle).
  - Back-to-back grants give one word per cycle.
- Handshake rules:
  - A core holds REQ and its ADDR stable until it sees GNT[k].
  - It may drop or change both in the cycle after the grant.
  - A core holding REQ continuously is re-granted at most once every NCORE non-write cycles when all cores request.
  - Worst-case wait = (NCORE-1) grants plus the number of write cycles.
- Read-after-write: a write at edge t followed by a grant to the same address in cycle t+1 returns the new data. No same-cycle read/write collision can occur, because writes block grants.
- A request arriving in the same cycle as WE is granted no earlier than the next non-write cycle.
- Asserting RST mid-burst:
  - DV clears immediately.
  - The in-flight word is discarded and is not replayed after reset.
  - Cores must re-request.
- ADDR bits of non-requesting cores are ignored.
- The design synthesises to one BRAM plus roughly NCORE*AW mux bits and arbiter logic.

Test Plan:
- Load: write MEM[0x005]=0x2A5A5 and MEM[0xFFF]=0x3FFFF. Then REQ=0001 with ADDR0=0x005 -> GNT=0001 in the same cycle; next cycle DQ=0x2A5A5, DV=0001, GIDX=0. Repeat with ADDR0=0xFFF -> DQ=0x3FFFF.
- Round robin: REQ=1111 held for 8 cycles with distinct addresses holding distinct data -> grant order 0,1,2,3,0,1,2,3; DV follows one cycle later; each DQ matches its core's address.
- Pointer wrap: after core 3 is granted, assert REQ=1001 -> core 0 is granted next, then core 3. With NCORE=3, REQ=111 -> order 0,1,2,0.
- Write priority: REQ=0010 with WE=1 for 3 cycles -> GNT=0 and DV=0 throughout. WE drops -> GNT=0010 in that cycle, DV=0010 the next.
- Read-after-write: write 0x11111 to 0x100 at edge t, then grant core 2 with ADDR2=0x100 in cycle t+1 -> DQ=0x11111 in cycle t+2 (the new value, not the old one).
- Reset: assert RST asynchronously mid-cycle while DV=0100 -> DV=0, DQ=0 and GNT=0 immediately. After release with REQ=1111 -> core 0 is granted first. Memory still holds the loaded data.
